// File: rtl/usb_pkg.sv
// Shared USB receive-side definitions: packet types, SYNC pattern, packet lengths,
// error codes and the CRC5/CRC16 helpers used when BS_DECODER_CRC_EN is defined.
package usb_pkg;

    typedef enum logic [1:0] {
        DATA   = 2'b00,
        TOKEN  = 2'b01,
        HSHAKE = 2'b10
    } pkt_type_e;

    localparam logic [7:0] SYNC        = 8'b0000_0001;
    localparam int         DATA_BITS   = 88;
    localparam int         TOKEN_BITS  = 24;
    localparam int         HSHAKE_BITS = 8;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_PID  = 2'b10;
    localparam logic [1:0] ERR_CRC  = 2'b11;

    // x^5+x^2+1, seeded with all ones, MSB first, complemented result
    function automatic logic [4:0] crc5(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 10; i >= 0; i--) begin
            c = {c[3:0], 1'b0} ^ ({5{c[4] ^ d[i]}} & 5'h05);
        end
        return ~c;
    endfunction

    function automatic logic [15:0] crc16(input logic [63:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 63; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ({16{c[15] ^ d[i]}} & 16'h8005);
        end
        return ~c;
    endfunction

endpackage

// File: rtl/sipo_register.sv
// Serial-in parallel-out shift register, MSB first; receive-side twin of the PISO.
module sipo_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear has priority over shifting so a new SYNC always starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_en) begin
            r_q <= {r_q[WIDTH-2:0], i_d};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bs_decoder.sv
// USB receive bitstream decoder: SYNC hunt, MSB-first packet capture, length/PID
// classification. Optional CRC checking is built when BS_DECODER_CRC_EN is defined.
module bs_decoder
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_in,
    input  logic        s_valid,
    input  logic        eop,
    input  logic        pkt_ack,
    output logic        pkt_valid,
    output logic [1:0]  pkt_type,
    output logic [87:0] data,
    output logic [23:0] token,
    output logic [7:0]  hshake,
    output logic        busy,
    output logic        pkt_err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE = 2'b00, RECV = 2'b01, DONE = 2'b10} state_e;

    localparam logic [6:0] L_DATA = 7'(DATA_BITS);
    localparam logic [6:0] L_TOK  = 7'(TOKEN_BITS);
    localparam logic [6:0] L_HS   = 7'(HSHAKE_BITS);

    state_e     r_state;
    logic [6:0] r_hunt;
    logic [6:0] r_cnt;
    pkt_type_e  r_pkt_type;
    logic       r_pkt_valid;
    logic       r_busy;
    logic       r_pkt_err;
    logic [1:0] r_err_code;

    logic [87:0] w_sr;
    logic [7:0]  w_hunt;
    logic        w_sync_hit;
    logic        w_shift;
    logic        w_overlen;
    logic [6:0]  w_cnt_post;
    logic [7:0]  w_pid;
    logic        w_len_ok;
    logic        w_pid_ok;
    logic        w_crc_bad;
    pkt_type_e   w_type;
    logic [1:0]  w_err_code;

    // r_hunt keeps the previous seven bits; w_hunt is the post-shift SYNC window
    assign w_hunt     = {r_hunt, s_in};
    assign w_sync_hit = (r_state == IDLE) && s_valid && (w_hunt == SYNC);
    assign w_shift    = (r_state == RECV) && s_valid;
    assign w_overlen  = w_shift && (r_cnt == L_DATA);
    assign w_cnt_post = r_cnt + {6'd0, w_shift};

    sipo_register #(.WIDTH(DATA_BITS)) u_sipo (
        .clk   (clk),
        .rst   (rst_n),
        .i_clr (w_sync_hit),
        .i_en  (w_shift),
        .i_d   (s_in),
        .o_q   (w_sr)
    );

    // Classify by post-shift length and pick the PID as it will sit after this bit
    always_comb begin
        w_len_ok = 1'b1;
        w_type   = DATA;
        w_pid    = 8'h00;
        case (w_cnt_post)
            L_HS: begin
                w_type = HSHAKE;
                w_pid  = w_shift ? {w_sr[6:0], s_in} : w_sr[7:0];
            end
            L_TOK: begin
                w_type = TOKEN;
                w_pid  = w_shift ? w_sr[22:15] : w_sr[23:16];
            end
            L_DATA: begin
                w_type = DATA;
                w_pid  = w_shift ? w_sr[86:79] : w_sr[87:80];
            end
            default: begin
                w_len_ok = 1'b0;
            end
        endcase
    end

    assign w_pid_ok = (w_pid[7:4] == ~w_pid[3:0]);

`ifdef BS_DECODER_CRC_EN
    logic [79:0] w_sr_post;

    assign w_sr_post = w_shift ? {w_sr[78:0], s_in} : w_sr[79:0];

    // Compare the received CRC field against one recomputed over the packet body
    always_comb begin
        w_crc_bad = 1'b0;
        case (w_type)
            TOKEN:   w_crc_bad = (crc5(w_sr_post[15:5]) != w_sr_post[4:0]);
            DATA:    w_crc_bad = (crc16(w_sr_post[79:16]) != w_sr_post[15:0]);
            default: w_crc_bad = 1'b0;
        endcase
    end
`else
    assign w_crc_bad = 1'b0;
`endif

    // Overlength wins over eop: the 89th bit is already an error
    always_comb begin
        w_err_code = ERR_NONE;
        if (w_overlen) begin
            w_err_code = ERR_LEN;
        end else if (eop) begin
            if (!w_len_ok) begin
                w_err_code = ERR_LEN;
            end else if (!w_pid_ok) begin
                w_err_code = ERR_PID;
            end else if (w_crc_bad) begin
                w_err_code = ERR_CRC;
            end else begin
                w_err_code = ERR_NONE;
            end
        end else begin
            w_err_code = ERR_NONE;
        end
    end

    // Receive FSM with registered status outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_hunt      <= 7'd0;
            r_cnt       <= 7'd0;
            r_pkt_type  <= DATA;
            r_pkt_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_pkt_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sync_hit) begin
                        r_state <= RECV;
                        r_cnt   <= 7'd0;
                        r_hunt  <= 7'd0;
                        r_busy  <= 1'b1;
                    end else if (s_valid) begin
                        r_hunt <= w_hunt[6:0];
                    end
                end
                RECV: begin
                    if (w_err_code != ERR_NONE) begin
                        r_pkt_err  <= 1'b1;
                        r_err_code <= w_err_code;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else if (eop) begin
                        r_pkt_valid <= 1'b1;
                        r_pkt_type  <= w_type;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end else if (w_shift) begin
                        r_cnt <= w_cnt_post;
                    end
                end
                DONE: begin
                    if (pkt_ack) begin
                        r_pkt_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign pkt_type  = r_pkt_type;
    assign data      = w_sr;
    assign token     = w_sr[23:0];
    assign hshake    = w_sr[7:0];
    assign busy      = r_busy;
    assign pkt_err   = r_pkt_err;
    assign err_code  = r_err_code;

endmodule

// File: doc/bs_decoder.md
# bs_decoder

Receive-side bitstream decoder for the USB link. It sits between the bit-unstuffer and the ProtocolFSM. It hunts for SYNC in the de-stuffed serial stream and shifts packet bits in MSB-first. At end-of-packet it classifies the packet by length as handshake, token or data, checks it, and presents it to the ProtocolFSM until that block acknowledges.

## Interface
- DATA_BITS, 88: data packet length after SYNC (PID + 64 payload + CRC16)
- TOKEN_BITS, 24: token packet length after SYNC (PID + addr7 + endp4 + CRC5)
- HSHAKE_BITS, 8: handshake packet length after SYNC (PID only)
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-high reset; asserted = 1 clears all state
- s_in  in  1  de-stuffed serial bit from the bit-unstuffer
- s_valid  in  1  s_in is a real bit this cycle; low on dropped stuffed bits and idle gaps
- eop  in  1  one-cycle end-of-packet strobe from the dpdm receiver
- pkt_ack  in  1  ProtocolFSM has consumed the presented packet
- pkt_valid  out  1  packet fields are valid and held stable
- pkt_type  out  2  00 data, 01 token, 10 handshake; meaningful only with pkt_valid
- data  out  88  PID[87:80], payload[79:16], CRC16[15:0]
- token  out  24  PID[23:16], addr[15:9], endp[8:5], CRC5[4:0]
- hshake  out  8  PID
- busy  out  1  packet reception in progress (RECV state)
- pkt_err  out  1  one-cycle error strobe
- err_code  out  2  01 length, 10 PID, 11 CRC; valid with pkt_err

## Operation
- The block uses a single 88-bit shift register `sr`. Each accepted bit does `sr <= {sr[86:0], s_in}`. The outputs are driven directly from it: data = sr, token = sr[23:0], hshake = sr[7:0].
- State IDLE:
  - An 8-bit hunt register shifts on every s_valid.
  - When the post-shift value equals 8'b0000_0001 (SYNC), the block moves to RECV, clears the 7-bit bit counter `cnt`, and clears `sr`.
  - eop is ignored in IDLE.
- State RECV:
  - On s_valid, shift s_in into `sr` and increment `cnt`.
  - If `cnt` would reach DATA_BITS+1, raise pkt_err with err_code 01 that same cycle and go to IDLE.
- eop in RECV, evaluated on the post-shift count (a bit and eop arriving in the same cycle are both honoured, bit first):
  - `cnt` is not 8, 24 or 88: pkt_err, err_code 01, go to IDLE.
  - PID high nibble is not the bitwise complement of the low nibble: pkt_err, err_code 10, go to IDLE.
  - CRC mismatch (only when CRC checking is configured in): pkt_err, err_code 11, go to IDLE.
  - Otherwise: go to DONE and set pkt_type from the length.
- State DONE:
  - pkt_valid = 1; `sr` and pkt_type are frozen.
  - s_valid, eop and SYNC hunting are ignored, so a packet arriving before the ack is dropped.
  - pkt_ack moves the block to IDLE. pkt_ack outside DONE is ignored.
- Reset, including mid-packet: state IDLE, `sr`, `cnt` and the hunt register all 0.

## Timing
- Reset values: pkt_valid 0, pkt_type 00, data/token/hshake 0, busy 0, pkt_err 0, err_code 00.
- SYNC completing on cycle t: busy = 1 from t+1.
- eop sampled on cycle t: pkt_valid = 1 (or pkt_err = 1) from t+1, and busy = 0 from t+1.
- Overlength error: pkt_err is registered and asserts the cycle after the 89th bit.
- pkt_ack sampled on cycle t: pkt_valid = 0 from t+1. SYNC hunting restarts at t+1 with a cleared hunt register.
- pkt_err is high for exactly one cycle. err_code holds its value until the next error.
- Gaps in s_valid of any length do not affect counting.

## Configuration
- BS_DECODER_CRC_EN defined:
  - Token: CRC5 is computed over token[15:5], MSB first, polynomial x^5+x^2+1, initial value 5'b11111, result complemented. It must equal token[4:0].
  - Data: CRC16 is computed over data[79:16], polynomial 16'h8005, initial value 16'hFFFF, result complemented. It must equal data[15:0].
  - A mismatch produces err_code 11.
- BS_DECODER_CRC_EN undefined: no CRC logic is built, and err_code 11 never occurs.

## Structure
- The shared package `usb_pkg` holds:
  - the pkt_type enum (DATA=2'b00, TOKEN=2'b01, HSHAKE=2'b10);
  - SYNC = 8'b0000_0001;
  - DATA_BITS, TOKEN_BITS, HSHAKE_BITS;
  - the err_code constants;
  - the functions crc5(11-bit) and crc16(64-bit).
- Sub-module `sipo_register` is parameterized by width, with clear, shift-enable and serial input. It mirrors the transmit-side PISO.
- The FSM (IDLE/RECV/DONE) stays inline in bs_decoder.

## Test plan
- Handshake: SYNC, then 8'hD2 MSB first, then eop -> next cycle pkt_valid = 1, pkt_type = 10, hshake = 8'hD2. pkt_ack -> pkt_valid = 0 the following cycle.
- Token: SYNC, PID 8'hE1, addr 7'h05, endp 4'h1 with correct CRC5, s_valid low on every third cycle, then eop -> pkt_type = 01 and the token fields match. Repeat with the CRC5 LSB flipped: with BS_DECODER_CRC_EN, pkt_err and err_code = 11; without it, pkt_valid = 1.
- Bad PID: SYNC, 8'hD3, eop -> pkt_err with err_code = 10, pkt_valid stays 0, and the block is back in IDLE.
- Length: SYNC + 12 bits + eop -> err_code = 01. SYNC + 89 bits with no eop -> pkt_err, err_code = 01, the cycle after bit 89.
- Data: SYNC + 88-bit packet (PID 8'hC3) with the last bit and eop in the same cycle -> pkt_type = 00 and data matches. A second SYNC+packet sent before pkt_ack is ignored.
- Reset asserted after 40 data bits -> all outputs return to reset values immediately. A subsequent handshake decodes correctly.
